// File: rtl/pong_game_sequencer.sv
// Game-flow controller for Pong: sequences idle/serve/rally/point/over phases,
// keeps both scores and drives the ball datapath's reset/run controls on frame boundaries.
module pong_game_sequencer #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       ball_reset,
  output logic       ball_run,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_CNT = 8'(POINT_FRAMES);
  localparam logic [3:0] WIN_CNT   = 4'(WIN_SCORE);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       serve_dir_q, serve_dir_d;
  logic       winner_q, winner_d;
  logic       start_q;
  logic       start_rise;

  assign start_rise = start & ~start_q;

  // Edge detector runs regardless of ena, so a press made while frozen is swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start;
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;

    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_d   = S_SERVE;
            cnt_d     = SERVE_CNT;
            score_l_d = 4'd0;
            score_r_d = 4'd0;
          end
        end
        S_SERVE: begin
          if (frame_tick) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (miss_l) begin
            score_r_d   = score_r_q + 4'd1;
            serve_dir_d = 1'b0;
            if (score_r_q + 4'd1 == WIN_CNT) begin
              state_d  = S_OVER;
              winner_d = 1'b1;
            end else begin
              state_d = S_POINT;
              cnt_d   = POINT_CNT;
            end
          end else if (miss_r) begin
            score_l_d   = score_l_q + 4'd1;
            serve_dir_d = 1'b1;
            if (score_l_q + 4'd1 == WIN_CNT) begin
              state_d  = S_OVER;
              winner_d = 1'b0;
            end else begin
              state_d = S_POINT;
              cnt_d   = POINT_CNT;
            end
          end
        end
        S_POINT: begin
          if (frame_tick) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_d = S_SERVE;
              cnt_d   = SERVE_CNT;
            end
          end
        end
        S_OVER: begin
          if (start_rise) begin
            state_d     = S_SERVE;
            cnt_d       = SERVE_CNT;
            score_l_d   = 4'd0;
            score_r_d   = 4'd0;
            serve_dir_d = ~winner_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
    end
  end

  // Datapath controls decode only from registered state: no input-to-output path.
  always_comb begin
    ball_reset = 1'b1;
    ball_run   = 1'b0;
    game_over  = 1'b0;
    unique case (state_q)
      S_PLAY: begin
        ball_reset = 1'b0;
        ball_run   = 1'b1;
      end
      S_POINT: ball_reset = 1'b0;
      S_OVER:  game_over  = 1'b1;
      default: ;
    endcase
  end

  assign state     = state_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign serve_dir = serve_dir_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Self-checking bench for pong_game_sequencer: directed game scenarios followed by
// randomized play, all compared against a phase/score reference model.
module tb_pong_game_sequencer;

  localparam int WIN   = 3;
  localparam int SERVE = 3;
  localparam int POINT = 2;

  logic       clk = 1'b0;
  logic       rst_n, ena, frame_tick, start, miss_l, miss_r;
  logic       ball_reset, ball_run, serve_dir, game_over, winner;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: game phase 0..4, frames remaining, scores, serve side, winner.
  int m_phase, m_left, m_sl, m_sr, m_dir, m_win, m_prev_start;

  pong_game_sequencer #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SERVE), .POINT_FRAMES(POINT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_tick(frame_tick), .start(start),
    .miss_l(miss_l), .miss_r(miss_r), .ball_reset(ball_reset), .ball_run(ball_run),
    .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_sl = 0; m_sr = 0;
    m_dir = 0; m_win = 0; m_prev_start = 0;
  endtask

  task automatic model_step(input bit en, input bit tick, input bit st, input bit ml, input bit mr);
    bit rise;
    int scorer;
    rise = st && !m_prev_start;
    m_prev_start = st;
    if (!en) return;
    case (m_phase)
      0: if (rise) begin m_phase = 1; m_left = SERVE; m_sl = 0; m_sr = 0; end
      1: if (tick) begin m_left--; if (m_left == 0) m_phase = 2; end
      2: if (ml || mr) begin
           if (ml) begin m_sr++; m_dir = 0; scorer = 1; end
           else    begin m_sl++; m_dir = 1; scorer = 0; end
           if ((scorer == 1 ? m_sr : m_sl) == WIN) begin m_phase = 4; m_win = scorer; end
           else begin m_phase = 3; m_left = POINT; end
         end
      3: if (tick) begin m_left--; if (m_left == 0) begin m_phase = 1; m_left = SERVE; end end
      4: if (rise) begin m_phase = 1; m_left = SERVE; m_sl = 0; m_sr = 0; m_dir = !m_win; end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},      8'(state),      8'(m_phase));
    check({tag, ".score_l"},    8'(score_l),    8'(m_sl));
    check({tag, ".score_r"},    8'(score_r),    8'(m_sr));
    check({tag, ".serve_dir"},  8'(serve_dir),  8'(m_dir));
    check({tag, ".winner"},     8'(winner),     8'(m_win));
    check({tag, ".ball_reset"}, 8'(ball_reset), 8'(m_phase == 0 || m_phase == 1 || m_phase == 4));
    check({tag, ".ball_run"},   8'(ball_run),   8'(m_phase == 2));
    check({tag, ".game_over"},  8'(game_over),  8'(m_phase == 4));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1ns later.
  task automatic step(input string tag, input bit en, input bit tick, input bit st,
                      input bit ml, input bit mr);
    ena = en; frame_tick = tick; start = st; miss_l = ml; miss_r = mr;
    @(posedge clk);
    model_step(en, tick, st, ml, mr);
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with start high; release while ena is low so the press is swallowed.
    rst_n = 1'b0; ena = 1'b0; frame_tick = 1'b0; start = 1'b1; miss_l = 1'b0; miss_r = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    check("reset.state_const", 8'(state), 8'd0);
    check("reset.ball_reset_const", 8'(ball_reset), 8'd1);
    rst_n = 1'b1;
    step("idle_ena_low", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("idle_held", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("idle_held2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("idle_stays", 8'(state), 8'd0);

    // Serve timing
    step("start_low", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("start_rise", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("serve_entered", 8'(state), 8'd1);
    ticks("serve_tick", 2);
    check("serve_after_2", 8'(state), 8'd1);
    ticks("serve_tick3", 1);
    check("play_entered", 8'(state), 8'd2);
    check("play_run", 8'(ball_run), 8'd1);
    check("play_noreset", 8'(ball_reset), 8'd0);

    // Point flow
    step("miss_l", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("miss_l.score_r", 8'(score_r), 8'd1);
    check("miss_l.dir", 8'(serve_dir), 8'd0);
    check("miss_l.state", 8'(state), 8'd3);
    check("miss_l.run_off", 8'(ball_run), 8'd0);
    ticks("point_tick", 2);
    check("point_to_serve", 8'(state), 8'd1);
    ticks("serve_tick", 3);
    check("serve_to_play", 8'(state), 8'd2);
    step("both_miss", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("both.score_r", 8'(score_r), 8'd2);
    check("both.score_l", 8'(score_l), 8'd0);

    // Game end: left player wins with three miss_r events (score_r stays 2)
    ticks("pt", 2); ticks("sv", 3);
    for (int k = 0; k < 3; k++) begin
      step("miss_r", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (k < 2) begin ticks("pt", 2); ticks("sv", 3); end
    end
    check("over.score_l", 8'(score_l), 8'd3);
    check("over.state", 8'(state), 8'd4);
    check("over.game_over", 8'(game_over), 8'd1);
    check("over.winner", 8'(winner), 8'd0);
    step("over_hold", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("over.held", 8'(score_l), 8'd3);
    step("restart", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("restart.state", 8'(state), 8'd1);
    check("restart.scores", 8'({score_l, score_r}), 8'd0);
    check("restart.dir", 8'(serve_dir), 8'd1);
    check("restart.game_over", 8'(game_over), 8'd0);

    // Enable freeze during SERVE
    for (int k = 0; k < 5; k++) step("freeze", 1'b0, 1'b1, 1'b0, k == 2, k == 3);
    check("freeze.state", 8'(state), 8'd1);
    check("freeze.scores", 8'({score_l, score_r}), 8'd0);
    ticks("thaw", 2);
    check("thaw_after_2", 8'(state), 8'd1);
    ticks("thaw3", 1);
    check("thaw_play", 8'(state), 8'd2);

    // Build score_r = 2, then assert reset between edges
    step("mr1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks("pt", 2); ticks("sv", 3);
    step("mr2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks("pt", 2); ticks("sv", 3);
    check("pre_reset.score_r", 8'(score_r), 8'd2);
    check("pre_reset.run", 8'(ball_run), 8'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    check("async_reset.score_r", 8'(score_r), 8'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Randomized play against the model
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit en, tk, st, ml, mr;
      en = ($urandom_range(0, 9) != 0);
      tk = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 7) == 0) ? ~start : start;
      ml = ($urandom_range(0, 15) == 0);
      mr = ($urandom_range(0, 15) == 0);
      step("rand", en, tk, st, ml, mr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pong_game_sequencer.md
# pong_game_sequencer

Top-level game-flow controller for the Pong design: sequences idle, serve, rally, point-pause and game-over phases, owns both players' scores, and drives the ball datapath's reset/run controls. Sits between the VGA frame-timing generator (frame tick), the synchronized player start button, and the ball/collision datapath (edge-miss flags). Every decision is made on frame boundaries so game pacing is independent of the pixel clock.

## Interface
Parameters:
- WIN_SCORE, 7, score that ends the game; legal 1..15
- SERVE_FRAMES, 60, frame ticks the ball stays centred before a rally; legal 1..255
- POINT_FRAMES, 30, frame ticks of frozen pause after a point; legal 1..255

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  design enable; low freezes all state
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  synchronized start button level
- miss_l  in  1  ball crossed left edge (right player scores)
- miss_r  in  1  ball crossed right edge (left player scores)
- ball_reset  out  1  ball datapath loads centre position
- ball_run  out  1  ball datapath may advance on frame_tick
- serve_dir  out  1  serve direction: 0 = toward left, 1 = toward right
- score_l  out  4  left player score
- score_r  out  4  right player score
- game_over  out  1  game finished
- winner  out  1  0 = left, 1 = right; valid while game_over = 1
- state  out  3  current state encoding (debug)

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; encodings 5..7 are unreachable and recover to IDLE on the next enabled cycle.
- start_q register holds the previous start level; start_rise = start & ~start_q. start_q updates every cycle, including while ena is low, so a press made while ena is low is never detected.
- 8-bit frame counter cnt is loaded on state entry. In SERVE/POINT it decrements on frame_tick. A frame_tick with cnt == 1 leaves the state, so the state lasts exactly N ticks.
- IDLE: ball_reset=1. start_rise → SERVE; scores cleared to 0; cnt=SERVE_FRAMES.
- SERVE: ball_reset=1, ball_run=0. Misses and start_rise are ignored. Final tick → PLAY.
- PLAY: ball_run=1.
  - miss_l: score_r+1, serve_dir=0.
  - else miss_r: score_l+1, serve_dir=1.
  - miss_l takes priority when both misses are high.
  - If the incremented score equals WIN_SCORE → OVER, with winner set to the scoring side. Otherwise → POINT with cnt=POINT_FRAMES.
- POINT: ball_reset=0, ball_run=0 (ball frozen). Misses ignored. Final tick → SERVE with cnt=SERVE_FRAMES.
- OVER: game_over=1, ball_reset=1. Scores hold. start_rise → SERVE; scores cleared; serve_dir=~winner; game_over clears.
- start_rise in SERVE/PLAY/POINT has no effect.
- Scores never exceed WIN_SCORE; no wrap.
- ena=0: state, cnt, scores, serve_dir, winner all hold; frame_tick and misses are ignored.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0, score_l=score_r=0, serve_dir=0, winner=0, start_q=0.
- Output values during reset: ball_reset=1, ball_run=0, game_over=0.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Latency: an input event sampled at edge N shows its state/score/output change after edge N (visible in cycle N+1).
- ball_run falls in the same cycle the score updates, so the datapath sees no extra run cycle after a miss.
- Reset asserted mid-rally aborts immediately to the reset values above. Deassertion is synchronized externally.

## Test plan
Bench parameters: WIN_SCORE=3, SERVE_FRAMES=3, POINT_FRAMES=2.
- Reset then idle: rst_n pulse low → state=0, ball_reset=1, ball_run=0, scores 0/0, game_over=0. Start held high across reset release with no subsequent rise → stays IDLE.
- Serve timing: start rise → state=1 next cycle. Two frame_ticks → still SERVE. Third tick → state=2, ball_run=1, ball_reset=0.
- Point flow: miss_l pulse in PLAY → score_r=1, serve_dir=0, state=3. Two ticks → SERVE. Three ticks → PLAY. miss_l+miss_r together → only score_r increments.
- Game end: three miss_r events → score_l=3, state=4, game_over=1, winner=0. Start rise → SERVE, scores 0/0, serve_dir=1, game_over=0.
- Enable freeze: ena=0 during SERVE with 5 frame_ticks and a miss → state, cnt and scores unchanged. ena=1 → three further ticks still required to reach PLAY.
- Async reset mid-PLAY: rst_n low between clock edges with score_r=2 → outputs return to reset values immediately, without waiting for a clock edge.
